// File: rtl/borsa_pkg.sv
// Shared widths, FSM state codes and LFSR step function for the encrypted decision sender.
package borsa_pkg;

    localparam int KARAR_W   = 10;
    localparam int ANAHTAR_W = 16;
    localparam int KAGIT_W   = 64;
    localparam int SIFRE_W   = 64;
    localparam int CARPIM_W  = KARAR_W + ANAHTAR_W;

    typedef logic [1:0] durum_t;
    localparam durum_t BOS    = 2'd0;
    localparam durum_t CARP   = 2'd1;
    localparam durum_t GONDER = 2'd2;

    // Taps 0,2,3,5 shifted in at the top; a nonzero state never maps to zero.
    function automatic logic [ANAHTAR_W-1:0] lfsr_sonraki(input logic [ANAHTAR_W-1:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[ANAHTAR_W-1:1]};
    endfunction

endpackage

// File: rtl/borsa_anahtar_lfsr.sv
// Seeded 16-bit key LFSR; advances only when adim_en is high, a zero seed is forced to 1.
module borsa_anahtar_lfsr
    import borsa_pkg::*;
#(
    parameter logic [ANAHTAR_W-1:0] ANAHTAR_TOHUM = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adim_en,
    output logic [ANAHTAR_W-1:0] deger
);

    localparam logic [ANAHTAR_W-1:0] TOHUM =
        (ANAHTAR_TOHUM == '0) ? 16'h0001 : ANAHTAR_TOHUM;

    logic [ANAHTAR_W-1:0] durum_q, durum_d;

    always_comb begin
        durum_d = durum_q;
        if (adim_en) begin
            durum_d = lfsr_sonraki(durum_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum_q <= TOHUM;
        end else begin
            durum_q <= durum_d;
        end
    end

    assign deger = durum_q;

endmodule

// File: rtl/borsa_sifre_verici.sv
// Encrypts one decision per transaction as karar_no * key (10-cycle shift-add), then holds it for a valid/ready send.
// Optional SIFRE_GURULTU_EN adds key>>1 noise to the encrypted word.
module borsa_sifre_verici
    import borsa_pkg::*;
#(
    parameter logic [ANAHTAR_W-1:0] ANAHTAR_TOHUM = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 giris_gecerli,
    output logic                 giris_hazir,
    input  logic [KARAR_W-1:0]   karar_no,
    input  logic [KAGIT_W-1:0]   kagit_sayisi,
    output logic                 cikis_gecerli,
    input  logic                 cikis_hazir,
    output logic [SIFRE_W-1:0]   sifre_cikisi,
    output logic [ANAHTAR_W-1:0] sifre_anahtari,
    output logic [KAGIT_W-1:0]   kagit_sayisi_cikis
);

    localparam logic [3:0] SON_ADIM = 4'(KARAR_W - 1);

    durum_t               durum_q, durum_d;
    logic [3:0]           sayac_q, sayac_d;
    logic [KARAR_W-1:0]   karar_q, karar_d;
    logic [ANAHTAR_W-1:0] anahtar_q, anahtar_d;
    logic [KAGIT_W-1:0]   kagit_q, kagit_d;
    logic [CARPIM_W-1:0]  acc_q, acc_d;
    logic [SIFRE_W-1:0]   sifre_q, sifre_d;
    logic [ANAHTAR_W-1:0] lfsr_deger;
    logic                 lfsr_adim;

    borsa_anahtar_lfsr #(
        .ANAHTAR_TOHUM (ANAHTAR_TOHUM)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .adim_en (lfsr_adim),
        .deger   (lfsr_deger)
    );

    always_comb begin
        durum_d   = durum_q;
        sayac_d   = sayac_q;
        karar_d   = karar_q;
        anahtar_d = anahtar_q;
        kagit_d   = kagit_q;
        acc_d     = acc_q;
        sifre_d   = sifre_q;
        lfsr_adim = 1'b0;
        case (durum_q)
            BOS: begin
                if (giris_gecerli) begin
                    karar_d   = karar_no;
                    kagit_d   = kagit_sayisi;
                    anahtar_d = lfsr_deger;
                    lfsr_adim = 1'b1;
                    acc_d     = '0;
                    sayac_d   = '0;
                    durum_d   = CARP;
                end
            end
            CARP: begin
                if (karar_q[sayac_q]) begin
                    acc_d = acc_q + (CARPIM_W'(anahtar_q) << sayac_q);
                end
                sayac_d = sayac_q + 4'd1;
                if (sayac_q == SON_ADIM) begin
                    durum_d = GONDER;
`ifdef SIFRE_GURULTU_EN
                    // Noise stays below the key, so word / key still yields karar_no.
                    sifre_d = SIFRE_W'(acc_d) + SIFRE_W'(anahtar_q >> 1);
`else
                    sifre_d = SIFRE_W'(acc_d);
`endif
                end
            end
            GONDER: begin
                if (cikis_hazir) begin
                    durum_d = BOS;
                end
            end
            default: durum_d = BOS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum_q   <= BOS;
            sayac_q   <= '0;
            karar_q   <= '0;
            anahtar_q <= '0;
            kagit_q   <= '0;
            acc_q     <= '0;
            sifre_q   <= '0;
        end else begin
            durum_q   <= durum_d;
            sayac_q   <= sayac_d;
            karar_q   <= karar_d;
            anahtar_q <= anahtar_d;
            kagit_q   <= kagit_d;
            acc_q     <= acc_d;
            sifre_q   <= sifre_d;
        end
    end

    assign giris_hazir        = (durum_q == BOS);
    assign cikis_gecerli      = (durum_q == GONDER);
    assign sifre_cikisi       = sifre_q;
    assign sifre_anahtari     = anahtar_q;
    assign kagit_sayisi_cikis = kagit_q;

endmodule

// File: tb/tb_borsa_sifre_verici.sv
// Bench for borsa_sifre_verici: directed plan cases plus random transactions against an arithmetic key/product model.
module tb_borsa_sifre_verici;

    logic        clk;
    logic        rst_n;
    logic        giris_gecerli, giris_hazir, cikis_gecerli, cikis_hazir;
    logic [9:0]  karar_no;
    logic [63:0] kagit_sayisi, sifre_cikisi, kagit_sayisi_cikis;
    logic [15:0] sifre_anahtari;

    logic        g0_vld, g0_rdy, c0_vld, c0_rdy;
    logic [9:0]  k0;
    logic [63:0] p0, s0, pc0;
    logic [15:0] a0;

    int n_vec;
    int n_err;
    int unsigned m_lfsr;

    borsa_sifre_verici u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .giris_gecerli      (giris_gecerli),
        .giris_hazir        (giris_hazir),
        .karar_no           (karar_no),
        .kagit_sayisi       (kagit_sayisi),
        .cikis_gecerli      (cikis_gecerli),
        .cikis_hazir        (cikis_hazir),
        .sifre_cikisi       (sifre_cikisi),
        .sifre_anahtari     (sifre_anahtari),
        .kagit_sayisi_cikis (kagit_sayisi_cikis)
    );

    borsa_sifre_verici #(.ANAHTAR_TOHUM(16'h0000)) u_dut0 (
        .clk                (clk),
        .rst_n              (rst_n),
        .giris_gecerli      (g0_vld),
        .giris_hazir        (g0_rdy),
        .karar_no           (k0),
        .kagit_sayisi       (p0),
        .cikis_gecerli      (c0_vld),
        .cikis_hazir        (c0_rdy),
        .sifre_cikisi       (s0),
        .sifre_anahtari     (a0),
        .kagit_sayisi_cikis (pc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Fibonacci taps 0,2,3,5 feeding bit 15, written as plain integer arithmetic.
    function automatic int unsigned model_step(input int unsigned s);
        int unsigned b;
        b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
        return (s >> 1) | (b << 15);
    endfunction

    function automatic longint unsigned model_word(input int unsigned k, input int unsigned key);
        longint unsigned w;
        w = longint'(k) * longint'(key);
`ifdef SIFRE_GURULTU_EN
        w = w + longint'(key / 2);
`endif
        return w;
    endfunction

    // Entered and left at a negedge with the DUT idle.
    task automatic send(input logic [9:0] k, input logic [63:0] c, input int stall);
        int unsigned key;
        longint unsigned w;
        int lat;
        chk("idle_rdy", 64'(giris_hazir), 64'd1);
        giris_gecerli = 1'b1;
        karar_no      = k;
        kagit_sayisi  = c;
        cikis_hazir   = (stall == 0);
        @(posedge clk);
        key    = m_lfsr;
        m_lfsr = model_step(m_lfsr);
        w      = model_word(k, key);
        @(negedge clk);
        giris_gecerli = 1'b0;
        karar_no      = 10'($urandom);
        kagit_sayisi  = {$urandom, $urandom};
        lat = 0;
        while (!cikis_gecerli && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'd10);
        chk("key", 64'(sifre_anahtari), 64'(key));
        chk("key_nonzero", 64'(sifre_anahtari != 16'd0), 64'd1);
        chk("word", sifre_cikisi, w);
        chk("count", kagit_sayisi_cikis, c);
        for (int i = 0; i < stall; i++) begin
            chk("stall_vld", 64'(cikis_gecerli), 64'd1);
            chk("stall_rdy", 64'(giris_hazir), 64'd0);
            chk("stall_word", sifre_cikisi, w);
            chk("stall_key", 64'(sifre_anahtari), 64'(key));
            chk("stall_count", kagit_sayisi_cikis, c);
            giris_gecerli = (i == stall / 2);
            @(negedge clk);
        end
        giris_gecerli = 1'b0;
        cikis_hazir   = 1'b1;
        if (stall != 0) @(negedge clk);
        @(negedge clk);
        chk("post_vld", 64'(cikis_gecerli), 64'd0);
        chk("post_rdy", 64'(giris_hazir), 64'd1);
    endtask

    initial begin
        int lat;
        n_vec = 0;
        n_err = 0;
        m_lfsr = 32'h0000_ACE1;
        rst_n = 1'b0;
        giris_gecerli = 1'b0;
        karar_no = '0;
        kagit_sayisi = '0;
        cikis_hazir = 1'b1;
        g0_vld = 1'b0;
        k0 = '0;
        p0 = '0;
        c0_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rdy", 64'(giris_hazir), 64'd1);
        chk("rst_vld", 64'(cikis_gecerli), 64'd0);
        chk("rst_word", sifre_cikisi, 64'd0);
        chk("rst_key", 64'(sifre_anahtari), 64'd0);
        chk("rst_count", kagit_sayisi_cikis, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(10'd5, 64'd100, 0);
        send(10'd1023, 64'hDEAD_BEEF_0123_4567, 0);
        send(10'd0, 64'd42, 0);
        send(10'd77, 64'd9, 20);

        // Reset during the fourth multiply cycle.
        giris_gecerli = 1'b1;
        karar_no = 10'd300;
        kagit_sayisi = 64'd555;
        @(posedge clk);
        @(negedge clk);
        giris_gecerli = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_word", sifre_cikisi, 64'd0);
        chk("mid_rst_key", 64'(sifre_anahtari), 64'd0);
        chk("mid_rst_count", kagit_sayisi_cikis, 64'd0);
        chk("mid_rst_vld", 64'(cikis_gecerli), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = 32'h0000_ACE1;
        @(negedge clk);
        send(10'd9, 64'd1, 0);

        for (int t = 0; t < 10; t++) begin
            send(10'($urandom), {$urandom, $urandom},
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end

        // Zero seed instance.
        g0_vld = 1'b1;
        k0 = 10'd7;
        p0 = 64'd3;
        @(posedge clk);
        @(negedge clk);
        g0_vld = 1'b0;
        lat = 0;
        while (!c0_vld && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("seed0_latency", 64'(lat), 64'd10);
        chk("seed0_key", 64'(a0), 64'd1);
        chk("seed0_word", s0, 64'd7);
        chk("seed0_count", pc0, 64'd3);
        @(negedge clk);
        chk("seed0_rdy", 64'(g0_rdy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
